// File: rtl/cpu_fetch_decode_if.sv
// Fetch/decode bus: instruction and memory status in,
// PC plus register-file and ALU controls out.
interface cpu_fetch_decode_if #(
  parameter int PC_WIDTH = 32
);
  logic [31:0]         INSTRUCTION;
  logic                BUSYWAIT;
  logic                ZERO;
  logic [PC_WIDTH-1:0] PC;
  logic [2:0]          WRITEADDR;
  logic [2:0]          READADDR1;
  logic [2:0]          READADDR2;
  logic                WRITEENABLE;
  logic [2:0]          ALUOP;
  logic [7:0]          IMMEDIATE;
  logic                IMM_SEL;
  logic                NEG_SEL;
  logic                ILLEGAL;

  modport master (
    output INSTRUCTION, BUSYWAIT, ZERO,
    input  PC, WRITEADDR, READADDR1, READADDR2,
    input  WRITEENABLE, ALUOP, IMMEDIATE,
    input  IMM_SEL, NEG_SEL, ILLEGAL
  );

  modport slave (
    input  INSTRUCTION, BUSYWAIT, ZERO,
    output PC, WRITEADDR, READADDR1, READADDR2,
    output WRITEENABLE, ALUOP, IMMEDIATE,
    output IMM_SEL, NEG_SEL, ILLEGAL
  );
endinterface

// File: rtl/cpu_fetch_decode.sv
// Fetch/decode stage: PC, combinational decode,
// jump/beq resolution, stall and illegal-opcode halt.
module cpu_fetch_decode #(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input logic CLK,
  input logic RESET,
  cpu_fetch_decode_if.slave bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t              state;
  logic [PC_WIDTH-1:0] pc_q;
  logic                ill_q;

  logic [7:0] opcode;
  logic [7:0] off8;
  logic       we;
  logic [2:0] aluop;
  logic       imm_sel;
  logic       neg_sel;
  logic       legal;
  logic       jump;
  logic       beq;

  logic [PC_WIDTH-1:0] pc4;
  logic [PC_WIDTH-1:0] offset;
  logic [PC_WIDTH-1:0] next_pc;
  logic                unused_bits;

  assign opcode      = bus.INSTRUCTION[31:24];
  assign off8        = bus.INSTRUCTION[23:16];
  assign unused_bits = ^bus.INSTRUCTION[15:11];

  always_comb begin
    we      = 1'b0;
    aluop   = 3'd0;
    imm_sel = 1'b0;
    neg_sel = 1'b0;
    legal   = 1'b1;
    jump    = 1'b0;
    beq     = 1'b0;
    unique case (opcode)
      8'h00: begin we = 1'b1; imm_sel = 1'b1; end
      8'h01: we = 1'b1;
      8'h02: begin we = 1'b1; aluop = 3'd1; end
      8'h03: begin
        we = 1'b1; aluop = 3'd1; neg_sel = 1'b1;
      end
      8'h04: begin we = 1'b1; aluop = 3'd2; end
      8'h05: begin we = 1'b1; aluop = 3'd3; end
      8'h06: jump = 1'b1;
      8'h07: begin
        beq = 1'b1; aluop = 3'd1; neg_sel = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  // Word offset: sign-extended byte field scaled by 4
  assign offset = {{(PC_WIDTH-10){off8[7]}}, off8, 2'b00};
  assign pc4    = pc_q + PC_WIDTH'(4);
  assign next_pc = (jump || (beq && bus.ZERO))
                 ? pc4 + offset : pc4;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pc_q  <= RESET_PC;
      state <= RUN;
      ill_q <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (bus.BUSYWAIT) begin
            state <= STALL;
          end else if (!legal) begin
            state <= HALT;
            ill_q <= 1'b1;
          end else begin
            pc_q <= next_pc;
          end
        end
        STALL: begin
          if (!bus.BUSYWAIT) state <= RUN;
        end
        HALT: state <= HALT;
        default: state <= HALT;
      endcase
    end
  end

  assign bus.PC          = pc_q;
  assign bus.ILLEGAL     = ill_q;
  assign bus.WRITEADDR   = bus.INSTRUCTION[18:16];
  assign bus.READADDR1   = bus.INSTRUCTION[10:8];
  assign bus.READADDR2   = bus.INSTRUCTION[2:0];
  assign bus.IMMEDIATE   = bus.INSTRUCTION[7:0];
  assign bus.ALUOP       = aluop;
  assign bus.IMM_SEL     = imm_sel;
  assign bus.NEG_SEL     = neg_sel;
  assign bus.WRITEENABLE = we && (state == RUN)
                        && !bus.BUSYWAIT && !RESET;

endmodule

// File: doc/cpu_fetch_decode.md
Name: cpu_fetch_decode

Overview:
Fetch and decode stage for the 8-bit single-issue CPU. It sits directly upstream of the 8x8 register file.
- Holds the program counter and decodes the 32-bit instruction word.
- Drives the register-file read/write addresses and the write enable.
- Drives the ALU operation and operand selects.
- Resolves jump and branch-if-equal, and freezes on a memory busy-wait or an illegal opcode.

Parameters:
PC_WIDTH, 32, program counter width in bits.
RESET_PC, 0, PC value loaded on reset.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
RESET  input  1  synchronous, active-high reset.
INSTRUCTION  input  32  instruction word at the current PC: [31:24] opcode, [23:16] dest/offset, [15:8] src1, [7:0] src2/immediate.
BUSYWAIT  input  1  memory stall; while high, PC and state hold and WRITEENABLE is 0.
ZERO  input  1  ALU zero flag for the current instruction (beq compare).
PC  output  PC_WIDTH  current instruction address.
WRITEADDR  output  3  register-file write address = INSTRUCTION[18:16].
READADDR1  output  3  = INSTRUCTION[10:8].
READADDR2  output  3  = INSTRUCTION[2:0].
WRITEENABLE  output  1  register-file write strobe.
ALUOP  output  3  0 FORWARD, 1 ADD, 2 AND, 3 OR.
IMMEDIATE  output  8  = INSTRUCTION[7:0].
IMM_SEL  output  1  1 = ALU operand 2 is IMMEDIATE.
NEG_SEL  output  1  1 = operand 2 is two's-complement negated (sub, beq).
ILLEGAL  output  1  sticky flag: an unknown opcode was executed.

Behaviour:
- Reset is synchronous, active-high, and dominates BUSYWAIT, branches and HALT.
  - On a reset edge: PC = RESET_PC, state = RUN, ILLEGAL = 0.
- Decode is combinational from INSTRUCTION, with zero cycles of latency.

Opcode decode (WE = write enable, IMM = IMM_SEL, NEG = NEG_SEL):
- 0x00 loadi: ALUOP 0, IMM 1, WE 1.
- 0x01 mov: ALUOP 0, IMM 0, WE 1.
- 0x02 add: ALUOP 1, WE 1.
- 0x03 sub: ALUOP 1, NEG 1, WE 1.
- 0x04 and: ALUOP 2, WE 1.
- 0x05 or: ALUOP 3, WE 1.
- 0x06 j: WE 0.
- 0x07 beq: ALUOP 1, NEG 1, WE 0.
- Any other opcode is illegal.

Output gating:
- WRITEENABLE = decoded WE AND state==RUN AND !BUSYWAIT AND !RESET.
- ALUOP, IMM_SEL and NEG_SEL are driven from decode in every state; with WRITEENABLE low they have no architectural effect.

State machine (RUN, STALL, HALT):
- RUN:
  - BUSYWAIT=1 -> STALL, PC holds.
  - Illegal opcode -> HALT, ILLEGAL=1, PC holds.
  - Otherwise PC = next_pc.
- STALL:
  - Holds PC.
  - Returns to RUN on the first edge where BUSYWAIT=0, with no PC update on that edge.
  - The held instruction is re-issued in RUN on the following cycle.
- HALT:
  - PC frozen, WRITEENABLE 0, ILLEGAL 1.
  - Exits only through RESET.

PC arithmetic:
- pc4 = PC+4.
- offset = sign-extend(INSTRUCTION[23:16]) << 2, sized to PC_WIDTH.
- next_pc = pc4 + offset for j, or for beq with ZERO=1; otherwise next_pc = pc4.
- Arithmetic is modulo 2^PC_WIDTH. PC 0xFFFFFFFC + 4 wraps to 0.
- Negative offset 0xFF gives target = PC+4-4 = PC, a legal self-loop.

Other edge cases:
- BUSYWAIT and an illegal opcode in the same RUN cycle: the stall wins. The opcode is re-evaluated after the stall.
- RESET asserted during STALL or HALT returns the block to RUN at RESET_PC on that edge.
- Only the low 3 bits of the address fields are used; bits [7:3] of each register field are ignored.

Test Plan:
- Reset then loadi r2,#0x2A (INSTRUCTION 0x0002002A) -> PC=0; WRITEADDR=2, IMMEDIATE=0x2A, IMM_SEL=1, ALUOP=0, WRITEENABLE=1; next edge PC=4.
- sub r3,r1,r5 (0x03030105) -> READADDR1=1, READADDR2=5, WRITEADDR=3, ALUOP=1, NEG_SEL=1, WRITEENABLE=1.
- At PC=8, j -2 (0x06FE0000) -> PC=4 next edge; j offset 0 -> PC=12.
- At PC=16, beq offset 3 (0x07030102): with ZERO=1 -> PC=32; with ZERO=0 -> PC=20; WRITEENABLE=0 in both cases.
- BUSYWAIT high for 3 cycles during add at PC=20 -> PC stays 20 and WRITEENABLE=0 throughout; after release, one RUN cycle with WRITEENABLE=1 then PC=24.
- Opcode 0x1F at PC=24 -> ILLEGAL=1, PC frozen at 24 for 10 cycles, WRITEENABLE=0; RESET -> PC=0, ILLEGAL=0.
